branch_resolve_ctrl: RTL

- Controller that sequences ID-stage branch resolution in the MIPS pipeline.
- Detects data dependencies of the branch's source registers on instructions still in EX/MEM.
- Stalls PC and IF/ID and injects ID/EX bubbles for the required cycles, then drives the comparator forwarding selects.
- On a taken branch it flushes IF/ID and raises BranchTaken; it also keeps saturating branch/taken/stall performance counters.

---
 rtl/branch_pkg.sv | 18 +
 rtl/branch_hazard_detect.sv | 54 +++++
 rtl/branch_resolve_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/branch_pkg.sv
// Shared constants and types for ID-stage branch resolution control.
package branch_pkg;

  localparam logic [5:0] OP_BLTZ = 6'h01;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_BLEZ = 6'h06;
  localparam logic [5:0] OP_BGTZ = 6'h07;

  localparam logic FWD_REG   = 1'b0;
  localparam logic FWD_EXMEM = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/branch_hazard_detect.sv
// Combinational hazard check for a branch in ID against the EX and MEM producers.
// Produces the stall count still required and the comparator forwarding selects.
module branch_hazard_detect
  import branch_pkg::*;
(
  input  logic [5:0] OpCode_ID,
  input  logic [4:0] Rs_ID,
  input  logic [4:0] Rt_ID,
  input  logic       RegWrite_EX,
  input  logic       MemRead_EX,
  input  logic [4:0] WriteReg_EX,
  input  logic       RegWrite_MEM,
  input  logic       MemRead_MEM,
  input  logic [4:0] WriteReg_MEM,
  output logic [1:0] need,
  output logic       fwd_a,
  output logic       fwd_b
);

  logic       use_rt;
  logic       ex_rs, ex_rt, mem_rs, mem_rt;
  logic [1:0] need_rs, need_rt;

  // Work out which sources the branch reads, match them against producers, and
  // take the worst-case stall over the sources actually read.
  always_comb begin
    use_rt = 1'b0;
    case (OpCode_ID)
      OP_BEQ, OP_BNE:           use_rt = 1'b1;
      OP_BLEZ, OP_BGTZ, OP_BLTZ: use_rt = 1'b0;
      default:                  use_rt = 1'b0;
    endcase

    ex_rs  = RegWrite_EX  && (WriteReg_EX  == Rs_ID) && (Rs_ID != 5'd0);
    mem_rs = RegWrite_MEM && (WriteReg_MEM == Rs_ID) && (Rs_ID != 5'd0);
    ex_rt  = use_rt && RegWrite_EX  && (WriteReg_EX  == Rt_ID) && (Rt_ID != 5'd0);
    mem_rt = use_rt && RegWrite_MEM && (WriteReg_MEM == Rt_ID) && (Rt_ID != 5'd0);

    need_rs = 2'd0;
    if (ex_rs)                     need_rs = MemRead_EX ? 2'd2 : 2'd1;
    else if (mem_rs && MemRead_MEM) need_rs = 2'd1;

    need_rt = 2'd0;
    if (ex_rt)                     need_rt = MemRead_EX ? 2'd2 : 2'd1;
    else if (mem_rt && MemRead_MEM) need_rt = 2'd1;

    need = (need_rs > need_rt) ? need_rs : need_rt;

    // An EX match on the same source is younger and wins; that case stalls instead.
    fwd_a = (mem_rs && !MemRead_MEM && !ex_rs) ? FWD_EXMEM : FWD_REG;
    fwd_b = (mem_rt && !MemRead_MEM && !ex_rt) ? FWD_EXMEM : FWD_REG;
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Sequences ID-stage branch resolution: stalls for EX/MEM dependencies, then
// resolves with forwarding selects, flushes on taken, and counts activity.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no branch pending; a branch resolves now or starts a stall
// WAIT  | branch held in ID; rem more stall cycles before it resolves
module branch_resolve_ctrl
  import branch_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Branch_ID,
  input  logic [5:0]       OpCode_ID,
  input  logic [4:0]       Rs_ID,
  input  logic [4:0]       Rt_ID,
  input  logic             RegWrite_EX,
  input  logic             MemRead_EX,
  input  logic [4:0]       WriteReg_EX,
  input  logic             RegWrite_MEM,
  input  logic             MemRead_MEM,
  input  logic [4:0]       WriteReg_MEM,
  input  logic             Zero,
  output logic             Stall_PC,
  output logic             Stall_IFID,
  output logic             Bubble_IDEX,
  output logic             Flush_IFID,
  output logic             FwdA_ID,
  output logic             FwdB_ID,
  output logic             BranchTaken,
  output logic [CNT_W-1:0] BranchCnt,
  output logic [CNT_W-1:0] TakenCnt,
  output logic [CNT_W-1:0] StallCnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [1:0]       rem_q, rem_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [1:0] need;
  logic       fwd_a, fwd_b;
  logic       stall, resolve;

  branch_hazard_detect u_hazard (
    .OpCode_ID    (OpCode_ID),
    .Rs_ID        (Rs_ID),
    .Rt_ID        (Rt_ID),
    .RegWrite_EX  (RegWrite_EX),
    .MemRead_EX   (MemRead_EX),
    .WriteReg_EX  (WriteReg_EX),
    .RegWrite_MEM (RegWrite_MEM),
    .MemRead_MEM  (MemRead_MEM),
    .WriteReg_MEM (WriteReg_MEM),
    .need         (need),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b)
  );

  // Next-state, Mealy control outputs and saturating counter updates.
  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    stall        = 1'b0;
    resolve      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Branch_ID) begin
          if (need != 2'd0) begin
            stall   = 1'b1;
            rem_d   = need - 2'd1;
            state_d = ST_WAIT;
          end else begin
            resolve = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        // Hazard inputs are ignored here; rem alone decides when to resolve.
        if (!Branch_ID) begin
          rem_d   = 2'd0;
          state_d = ST_IDLE;
        end else if (rem_q != 2'd0) begin
          stall = 1'b1;
          rem_d = rem_q - 2'd1;
        end else begin
          resolve = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        rem_d   = 2'd0;
        state_d = ST_IDLE;
      end
    endcase

    // Reset dominates: no control output may assert in the reset cycle.
    if (!reset) begin
      stall   = 1'b0;
      resolve = 1'b0;
    end

    Stall_PC    = stall;
    Stall_IFID  = stall;
    Bubble_IDEX = stall;
    BranchTaken = resolve && Zero;
    Flush_IFID  = resolve && Zero;
    FwdA_ID     = resolve ? fwd_a : FWD_REG;
    FwdB_ID     = resolve ? fwd_b : FWD_REG;

    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (resolve && (branch_cnt_q != '1))       branch_cnt_d = branch_cnt_q + CNT_ONE;
    if (resolve && Zero && (taken_cnt_q != '1)) taken_cnt_d  = taken_cnt_q + CNT_ONE;
    if (stall && (stall_cnt_q != '1))          stall_cnt_d  = stall_cnt_q + CNT_ONE;
  end

  // State, stall counter and performance counters with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      rem_q        <= 2'd0;
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      branch_cnt_q <= branch_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign BranchCnt = branch_cnt_q;
  assign TakenCnt  = taken_cnt_q;
  assign StallCnt  = stall_cnt_q;

endmodule
